// File: rtl/param_ram_init_if.sv
// param_ram_init_if: request/response bus of the self-initialising RAM
interface param_ram_init_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic rd;
  logic wr;
  logic [DATA_W-1:0] data_out;
  logic rd_valid;
  logic ready;
  logic err;
  modport master(output addr, data_in, rd, wr, input data_out, rd_valid, ready, err);
  modport slave(input addr, data_in, rd, wr, output data_out, rd_valid, ready, err);
endinterface

// File: rtl/param_ram_init.sv
// param_ram_init: single-port RAM that clears itself to INIT_VAL after every reset
module param_ram_init #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic clk,
  input logic rst,
  param_ram_init_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, IDLE} state_t;
  state_t st;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  // INIT owns the write port (sweeping cnt); in IDLE the bus does; nothing is written under reset
  always_comb begin
    we = !rst && (st == INIT || bus.wr);
    wa = st == INIT ? cnt : bus.addr;
    wd = st == INIT ? INIT_VAL : bus.data_in;
  end
  // storage array, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // init sequencer, registered read path and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= INIT;
      cnt <= '0;
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.ready <= 1'b0;
      bus.err <= 1'b0;
    end else if (st == INIT) begin
      cnt <= cnt + 1'b1;
      bus.rd_valid <= 1'b0;
      bus.err <= bus.rd | bus.wr;
      if (cnt == '1) begin
        st <= IDLE;
        bus.ready <= 1'b1;
      end
    end else begin
      bus.rd_valid <= bus.rd;
      bus.err <= 1'b0;
      if (bus.rd) bus.data_out <= bus.wr ? bus.data_in : mem[bus.addr];
    end
  end
endmodule

// File: tb/tb_param_ram_init.sv
// tb_param_ram_init: randomized checks of both a default and a small BEEF-initialised RAM
module tb_param_ram_init;
  logic clk;
  logic rst_a;
  logic rst_b;
  int total;
  int bad;
  logic [7:0] ref_a [32];
  logic [7:0] exp_do;
  logic exp_rv;
  param_ram_init_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();
  param_ram_init_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();
  param_ram_init #(.DATA_W(8), .ADDR_W(5), .INIT_VAL(8'h00)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  param_ram_init #(.DATA_W(16), .ADDR_W(3), .INIT_VAL(16'hBEEF)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_a[i] = 8'h00;
    exp_do = 8'h00;
    exp_rv = 1'b0;
  endtask
  task automatic step_a(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    bus_a.rd = r;
    bus_a.wr = w;
    bus_a.addr = a;
    bus_a.data_in = d;
    exp_rv = r;
    if (r) exp_do = w ? d : ref_a[a];
    if (w) ref_a[a] = d;
    cyc();
    bus_a.rd = 1'b0;
    bus_a.wr = 1'b0;
  endtask
  task automatic wait_ready_a(output int n);
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    cyc();
    total++;
    if ({bus_a.ready, bus_a.rd_valid, bus_a.err, bus_a.data_out} !== 11'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b do=%h want all zero", bus_a.ready, bus_a.rd_valid, bus_a.err, bus_a.data_out);
    end
    rst_a = 1'b0;
    model_reset();
    wait_ready_a(n);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL init_length: got %0d cycles want 32", n);
    end
  endtask
  task automatic test_init_read();
    for (int i = 0; i < 32; i++) begin
      step_a(1'b1, 1'b0, 5'(i), 8'h00);
      total++;
      if (bus_a.data_out !== 8'h00 || bus_a.rd_valid !== 1'b1) begin
        bad++;
        $display("FAIL init_read[%0d]: got do=%h rv=%b want do=00 rv=1", i, bus_a.data_out, bus_a.rd_valid);
      end
    end
    step_a(1'b0, 1'b0, 5'd0, 8'h00);
    total++;
    if (bus_a.rd_valid !== 1'b0 || bus_a.data_out !== 8'h00) begin
      bad++;
      $display("FAIL read_hold: got do=%h rv=%b want do=00 rv=0", bus_a.data_out, bus_a.rd_valid);
    end
  endtask
  task automatic test_write_read();
    step_a(1'b0, 1'b1, 5'd5, 8'hA5);
    total++;
    if (bus_a.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_no_valid: got rv=%b want 0", bus_a.rd_valid);
    end
    step_a(1'b1, 1'b0, 5'd5, 8'h00);
    total++;
    if (bus_a.data_out !== 8'hA5 || bus_a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL write_read: got do=%h rv=%b want do=a5 rv=1", bus_a.data_out, bus_a.rd_valid);
    end
  endtask
  task automatic test_bypass();
    step_a(1'b1, 1'b1, 5'd31, 8'h3C);
    total++;
    if (bus_a.data_out !== 8'h3C || bus_a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL bypass: got do=%h rv=%b want do=3c rv=1", bus_a.data_out, bus_a.rd_valid);
    end
    step_a(1'b1, 1'b0, 5'd0, 8'h00);
    step_a(1'b1, 1'b0, 5'd31, 8'h00);
    total++;
    if (bus_a.data_out !== 8'h3C) begin
      bad++;
      $display("FAIL bypass_stored: got do=%h want 3c", bus_a.data_out);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step_a(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 5'($urandom), 8'($urandom));
      total++;
      if (bus_a.data_out !== exp_do || bus_a.rd_valid !== exp_rv || bus_a.err !== 1'b0 || bus_a.ready !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d]: got do=%h rv=%b err=%b rdy=%b want do=%h rv=%b err=0 rdy=1", i, bus_a.data_out, bus_a.rd_valid, bus_a.err, bus_a.ready, exp_do, exp_rv);
      end
    end
  endtask
  task automatic test_init_err();
    int n;
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    model_reset();
    for (int i = 0; i < 9; i++) cyc();
    bus_a.wr = 1'b1;
    bus_a.addr = 5'd2;
    bus_a.data_in = 8'hFF;
    cyc();
    bus_a.wr = 1'b0;
    total++;
    if (bus_a.err !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.ready !== 1'b0) begin
      bad++;
      $display("FAIL init_err: got err=%b rv=%b rdy=%b want err=1 rv=0 rdy=0", bus_a.err, bus_a.rd_valid, bus_a.ready);
    end
    cyc();
    total++;
    if (bus_a.err !== 1'b0) begin
      bad++;
      $display("FAIL init_err_pulse: got err=%b want 0", bus_a.err);
    end
    wait_ready_a(n);
    total++;
    if (n !== 21) begin
      bad++;
      $display("FAIL init_err_length: got %0d more cycles want 21", n);
    end
    step_a(1'b1, 1'b0, 5'd2, 8'h00);
    total++;
    if (bus_a.data_out !== 8'h00 || bus_a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL init_err_read: got do=%h rv=%b want do=00 rv=1", bus_a.data_out, bus_a.rd_valid);
    end
  endtask
  task automatic test_async_reset();
    int n;
    step_a(1'b0, 1'b1, 5'd7, 8'h77);
    step_a(1'b1, 1'b0, 5'd7, 8'h00);
    total++;
    if (bus_a.data_out !== 8'h77 || bus_a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_read: got do=%h rv=%b want do=77 rv=1", bus_a.data_out, bus_a.rd_valid);
    end
    #2 rst_a = 1'b1;
    #1;
    total++;
    if ({bus_a.ready, bus_a.rd_valid, bus_a.err, bus_a.data_out} !== 11'h0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%b rv=%b err=%b do=%h want all zero", bus_a.ready, bus_a.rd_valid, bus_a.err, bus_a.data_out);
    end
    cyc();
    cyc();
    rst_a = 1'b0;
    model_reset();
    wait_ready_a(n);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL reinit_length: got %0d cycles want 32", n);
    end
    step_a(1'b1, 1'b0, 5'd7, 8'h00);
    total++;
    if (bus_a.data_out !== 8'h00 || bus_a.rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL reinit_read7: got do=%h rv=%b want do=00 rv=1", bus_a.data_out, bus_a.rd_valid);
    end
    step_a(1'b1, 1'b0, 5'd31, 8'h00);
    total++;
    if (bus_a.data_out !== 8'h00) begin
      bad++;
      $display("FAIL reinit_read31: got do=%h want 00", bus_a.data_out);
    end
  endtask
  task automatic test_small_config();
    int n;
    logic [15:0] small_ref [8];
    logic [2:0] a;
    logic [15:0] d;
    logic w;
    logic r;
    logic [15:0] exp_b;
    rst_b = 1'b0;
    n = 0;
    while (bus_b.ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL small_init_length: got %0d cycles want 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      small_ref[i] = 16'hBEEF;
      bus_b.rd = 1'b1;
      bus_b.addr = 3'(i);
      cyc();
      total++;
      if (bus_b.data_out !== 16'hBEEF || bus_b.rd_valid !== 1'b1) begin
        bad++;
        $display("FAIL small_read[%0d]: got do=%h rv=%b want do=beef rv=1", i, bus_b.data_out, bus_b.rd_valid);
      end
    end
    exp_b = 16'hBEEF;
    for (int i = 0; i < 60; i++) begin
      a = 3'($urandom);
      d = 16'($urandom);
      w = $urandom_range(0, 2) == 0;
      r = 1'($urandom_range(0, 1));
      bus_b.addr = a;
      bus_b.data_in = d;
      bus_b.wr = w;
      bus_b.rd = r;
      if (r) exp_b = w ? d : small_ref[a];
      if (w) small_ref[a] = d;
      cyc();
      total++;
      if (bus_b.data_out !== exp_b || bus_b.rd_valid !== r) begin
        bad++;
        $display("FAIL small_random[%0d]: got do=%h rv=%b want do=%h rv=%b", i, bus_b.data_out, bus_b.rd_valid, exp_b, r);
      end
    end
    bus_b.rd = 1'b0;
    bus_b.wr = 1'b0;
  endtask
  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.rd = 1'b0;
    bus_a.wr = 1'b0;
    bus_a.addr = '0;
    bus_a.data_in = '0;
    bus_b.rd = 1'b0;
    bus_b.wr = 1'b0;
    bus_b.addr = '0;
    bus_b.data_in = '0;
    model_reset();
    test_reset();
    test_init_read();
    test_write_read();
    test_bypass();
    test_random();
    test_init_err();
    test_async_reset();
    test_small_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
